l1_cache_ctrl: RTL and testbench
================================

// Module: l1_cache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 data cache controller; sits upstream of the line adapter.
//  Serves 32-bit CPU loads/stores from a local 256-bit line store.
//  On a miss it drives the adapter's re/we/toggle handshake: evicts the dirty victim line, then refills.
//  The adapter carries each transfer to memory as eight 32-bit beats.
// PARAMETERS
//  NUM_LINES   16   lines in cache (power of 2); INDEX_W = $clog2(NUM_LINES)
//  LINE_BITS   256  line width; 8 words/line, offset = addr[4:0], word sel = addr[4:2]
// PORTS
//  CLK          in   1    clock
//  RST          in   1    reset, synchronous, active-high
//  cpu_re       in   1    CPU load request
//  cpu_we       in   1    CPU store request (priority over cpu_re if both high)
//  cpu_addr     in   32   byte address; index = [4+INDEX_W:5], tag = [31:5+INDEX_W]
//  cpu_wdata    in   32   store data
//  cpu_be       in   4    store byte enables
//  cpu_rdata    out  32   load data, valid when request high and cpu_stall low
//  cpu_stall    out  1    high while request cannot complete this cycle
//  ad_re        out  1    adapter read (refill) request, held until ad_ready
//  ad_we        out  1    adapter write (evict) request, held until ad_ready
//  ad_toggle    out  1    one-cycle start pulse, first cycle of each transfer
//  ad_line_out  out  256  victim line to adapter (stable while ad_we high)
//  ad_line_addr out  32   line-aligned memory address of current transfer ([4:0]=0)
//  ad_line_in   in   256  refill line from adapter, sampled on ad_ready
//  ad_ready     in   1    adapter transfer complete (single-cycle pulse)
// BEHAVIOUR
//  Reset: all valid and dirty bits cleared, FSM -> IDLE. Outputs: ad_re=ad_we=ad_toggle=0, ad_line_addr=0,
//   cpu_stall=0, cpu_rdata=0. Data and tag arrays are not cleared.
//  States: IDLE, WRITEBACK, ALLOCATE, REFILLED.
//  IDLE, no request: cpu_stall=0.
//  IDLE, request, hit (valid && tag match): cpu_stall=0, zero-wait.
//   Load: cpu_rdata = combinational word select.
//   Store: bytes merged per cpu_be at the next edge; line dirty=1.
//  IDLE, request, miss: cpu_stall=1 combinationally; addr/wdata/be/re/we latched at the edge.
//   Victim valid && dirty -> WRITEBACK; otherwise -> ALLOCATE.
//  WRITEBACK
//   ad_we=1; ad_toggle=1 on first cycle only.
//   ad_line_addr = {victim_tag, index, 5'b0}; ad_line_out = victim line.
//   On ad_ready -> ALLOCATE.
//  ALLOCATE
//   ad_re=1; ad_toggle=1 on first cycle only; ad_line_addr = {req_tag, index, 5'b0}.
//   On ad_ready: write ad_line_in, tag=req_tag, valid=1, dirty=0 -> REFILLED.
//  REFILLED: cpu_stall=1 for one cycle -> IDLE, where the held request hits.
//   Miss latency = adapter time + 2 cycles (clean) or + 2 adapter transfers (dirty).
//  ad_re and ad_we are never high together; ad_toggle never high in IDLE/REFILLED.
//  ad_ready outside WRITEBACK/ALLOCATE: ignored.
//  cpu_stall stays high through WRITEBACK/ALLOCATE/REFILLED.
//  CPU must hold its request while stalled; the latched address is used regardless.
//  cpu_be=0 store: counts as an access (allocates on miss, sets dirty on hit) but alters no bytes.
//  RST mid-transfer: FSM aborts to IDLE, ad_* deassert next cycle, the partial refill is never written.
// STRUCTURE
//  cache_pkg:
//   - ctrl_state_t enum (IDLE/WRITEBACK/ALLOCATE/REFILLED)
//   - LINE_BITS, WORDS_PER_LINE=8, OFFSET_W=5
//   - addr field helper functions
//  Sub-module cache_line_store:
//   - tag/valid/dirty/data arrays, async read
//   - sync write with word + byte-enable merge, full-line write, valid/dirty clear on RST
//  l1_cache_ctrl holds the FSM, request latch and adapter-side muxing.
// TESTING (bench models adapter: ready N cycles after toggle, N=9)
//  Cold load 0x0000_0104 -> stall, one toggle with ad_re, ad_line_addr=0x100.
//   Refill words 0..7 = 0xA0..0xA7 -> cpu_rdata=0xA1 when stall drops.
//  Store 0xDEADBEEF be=4'b0011 to 0x104 (hit) -> no stall; subsequent load 0x104 returns 0x0000BEEF.
//  Load 0x304 (same index, new tag) after dirty store:
//   WRITEBACK with ad_line_addr=0x100, ad_line_out word1=0x0000BEEF,
//   then ALLOCATE with ad_line_addr=0x300; ad_we/ad_re never overlap.
//  Clean conflict miss -> straight to ALLOCATE; no ad_we pulse.
//  RST asserted 3 cycles into ALLOCATE -> ad_re=0 next cycle, stall=0.
//   Reload of 0x104 misses again (valid cleared).
//  Back-to-back hits to 8 different words of one line -> 8 completions in 8 cycles, stall never high.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, geometry constants and address-field helpers for the L1 data cache.
// Field helpers take the index width so one package serves any power-of-two line count.
package cache_pkg;

  localparam int LINE_BITS      = 256;
  localparam int WORD_BITS      = 32;
  localparam int WORDS_PER_LINE = LINE_BITS / WORD_BITS;
  localparam int OFFSET_W       = 5;
  localparam int WSEL_W         = $clog2(WORDS_PER_LINE);

  // A line viewed as an array of 32-bit words; bit-compatible with a flat 256-bit vector.
  typedef logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILLED
  } ctrl_state_t;

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w);
    return (addr >> OFFSET_W) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w);
    return addr >> (OFFSET_W + index_w);
  endfunction

  function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] addr);
    return WSEL_W'(addr >> 2);
  endfunction

  // Rebuild the line-aligned byte address of a line from its tag and index.
  function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] index,
                                            input int index_w);
    return (tag << (OFFSET_W + index_w)) | (index << OFFSET_W);
  endfunction

endpackage

// File: rtl/l1_cache_ctrl_if.sv
// CPU request port and line-adapter handshake of the L1 data cache, bundled as one interface.
// The controller connects through 'slave'; the CPU/adapter side (or a bench) uses 'master'.
interface l1_cache_ctrl_if;
  import cache_pkg::*;

  logic                 cpu_re;
  logic                 cpu_we;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [3:0]           cpu_be;
  logic [31:0]          cpu_rdata;
  logic                 cpu_stall;

  logic                 ad_re;
  logic                 ad_we;
  logic                 ad_toggle;
  logic [LINE_BITS-1:0] ad_line_out;
  logic [31:0]          ad_line_addr;
  logic [LINE_BITS-1:0] ad_line_in;
  logic                 ad_ready;

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_rdata, cpu_stall,
    input  ad_re, ad_we, ad_toggle, ad_line_out, ad_line_addr,
    output ad_line_in, ad_ready
  );

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_rdata, cpu_stall,
    output ad_re, ad_we, ad_toggle, ad_line_out, ad_line_addr,
    input  ad_line_in, ad_ready
  );

endinterface

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data storage for a direct-mapped cache: asynchronous read of one line,
// synchronous byte-merged word store or full-line refill at the same index.
module cache_line_store
  import cache_pkg::*;
#(
  parameter  int NUM_LINES = 16,
  localparam int INDEX_W   = $clog2(NUM_LINES),
  localparam int TAG_W     = 32 - OFFSET_W - INDEX_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [INDEX_W-1:0] index,
  output logic               valid,
  output logic               dirty,
  output logic [TAG_W-1:0]   tag,
  output line_t              line,
  input  logic               word_we,
  input  logic [WSEL_W-1:0]  word_sel,
  input  logic [31:0]        wdata,
  input  logic [3:0]         be,
  input  logic               fill_we,
  input  logic [TAG_W-1:0]   fill_tag,
  input  line_t              fill_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  line_t                data_q [NUM_LINES];

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign line  = data_q[index];

  // A store with no byte enables still marks the line dirty: it is an access like any other.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits gate every use of them,
  // and keeping reset off the storage lets it map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_line;
    end else if (word_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) data_q[index][word_sel][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller: hits complete with zero
// wait; misses evict a dirty victim, then refill the line through the adapter handshake.
module l1_cache_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input  logic          CLK,
  input  logic          RST,
  l1_cache_ctrl_if.slave bus
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 32 - OFFSET_W - INDEX_W;

  ctrl_state_t        state;
  logic [31:0]        req_addr;
  logic               ad_re_q;
  logic               ad_we_q;
  logic               ad_toggle_q;
  logic [31:0]        ad_line_addr_q;

  logic [INDEX_W-1:0] cpu_index;
  logic [INDEX_W-1:0] req_index;
  logic [INDEX_W-1:0] line_index;
  logic [TAG_W-1:0]   cpu_tag;
  logic [TAG_W-1:0]   req_tag;
  logic [WSEL_W-1:0]  cpu_word;

  logic               rd_valid;
  logic               rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  line_t              rd_line;

  logic               idle;
  logic               cpu_req;
  logic               hit;
  logic               store_hit;
  logic               fill_we;

  assign cpu_index = INDEX_W'(addr_index(bus.cpu_addr, INDEX_W));
  assign cpu_tag   = TAG_W'(addr_tag(bus.cpu_addr, INDEX_W));
  assign cpu_word  = addr_word(bus.cpu_addr);
  assign req_index = INDEX_W'(addr_index(req_addr, INDEX_W));
  assign req_tag   = TAG_W'(addr_tag(req_addr, INDEX_W));

  // Outside IDLE the store is addressed by the latched request so the victim and refill
  // target stay fixed even if the CPU address wanders.
  assign idle       = (state == IDLE);
  assign line_index = idle ? cpu_index : req_index;

  assign cpu_req   = bus.cpu_re | bus.cpu_we;
  assign hit       = rd_valid && (rd_tag == cpu_tag);
  assign store_hit = idle && bus.cpu_we && hit && !RST;
  assign fill_we   = (state == ALLOCATE) && bus.ad_ready && !RST;

  cache_line_store #(
    .NUM_LINES (NUM_LINES)
  ) u_store (
    .CLK       (CLK),
    .RST       (RST),
    .index     (line_index),
    .valid     (rd_valid),
    .dirty     (rd_dirty),
    .tag       (rd_tag),
    .line      (rd_line),
    .word_we   (store_hit),
    .word_sel  (cpu_word),
    .wdata     (bus.cpu_wdata),
    .be        (bus.cpu_be),
    .fill_we   (fill_we),
    .fill_tag  (req_tag),
    .fill_line (bus.ad_line_in)
  );

  // A miss stalls in the same cycle it is presented; the FSM picks it up at the next edge.
  assign bus.cpu_stall = !idle || (cpu_req && !hit);
  assign bus.cpu_rdata = (idle && bus.cpu_re && !bus.cpu_we && hit) ? rd_line[cpu_word] : '0;

  assign bus.ad_re        = ad_re_q;
  assign bus.ad_we        = ad_we_q;
  assign bus.ad_toggle    = ad_toggle_q;
  assign bus.ad_line_addr = ad_line_addr_q;
  assign bus.ad_line_out  = rd_line;

  // NOTE: every assignment in this block is non-blocking, so the ad_toggle default at the
  // top is simply overridden by a later assignment made on a transfer-starting edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      req_addr       <= '0;
      ad_re_q        <= 1'b0;
      ad_we_q        <= 1'b0;
      ad_toggle_q    <= 1'b0;
      ad_line_addr_q <= '0;
    end else begin
      ad_toggle_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req && !hit) begin
            req_addr    <= bus.cpu_addr;
            ad_toggle_q <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state          <= WRITEBACK;
              ad_we_q        <= 1'b1;
              ad_line_addr_q <= line_addr(32'(rd_tag), 32'(cpu_index), INDEX_W);
            end else begin
              state          <= ALLOCATE;
              ad_re_q        <= 1'b1;
              ad_line_addr_q <= line_addr(32'(cpu_tag), 32'(cpu_index), INDEX_W);
            end
          end
        end
        WRITEBACK: begin
          if (bus.ad_ready) begin
            state          <= ALLOCATE;
            ad_we_q        <= 1'b0;
            ad_re_q        <= 1'b1;
            ad_toggle_q    <= 1'b1;
            ad_line_addr_q <= line_addr(32'(req_tag), 32'(req_index), INDEX_W);
          end
        end
        ALLOCATE: begin
          if (bus.ad_ready) begin
            state   <= REFILLED;
            ad_re_q <= 1'b0;
          end
        end
        REFILLED: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Scoreboard bench for l1_cache_ctrl: directed CPU accesses push expected completions and
// adapter transfers into queues; a negedge monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_l1_cache_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_cache_ctrl_if bus();

  l1_cache_ctrl #(.NUM_LINES(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
  } cpu_exp_t;

  typedef struct {
    logic         is_write;
    logic [31:0]  addr;
    logic         chk_line;
    logic [255:0] line;
  } ad_exp_t;

  cpu_exp_t     cpu_q[$];
  ad_exp_t      ad_q[$];
  logic [255:0] mem [logic [31:0]];

  int n_tests     = 0;
  int n_fail      = 0;
  int overlap_cnt = 0;
  int cyc         = 0;

  always @(posedge clk) cyc++;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%064h, expected 0x%064h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  function automatic logic [255:0] make_line(input logic [7:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {24'h0, base + 8'(i)};
    return l;
  endfunction

  task automatic push_ad(input logic is_write, input logic [31:0] addr,
                         input logic chk_line, input logic [255:0] line);
    ad_exp_t e;
    e.is_write = is_write;
    e.addr     = addr;
    e.chk_line = chk_line;
    e.line     = line;
    ad_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the access completes, request dropped.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input int exp_wait);
    cpu_exp_t e;
    int waits;
    e.is_load = !we;
    e.rdata   = exp_rdata;
    cpu_q.push_back(e);
    bus.cpu_re    = !we;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_be    = be;
    waits = 0;
    forever begin
      @(negedge clk);
      if (!bus.cpu_stall) break;
      waits++;
      if (waits > 200) begin
        check_word("req_timeout", addr, 32'hFFFF_FFFF);
        void'(cpu_q.pop_back());
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    check_word("wait_cycles", 32'(waits), 32'(exp_wait));
  endtask

  // Adapter model: answers each transfer with a one-cycle ad_ready nine cycles after ad_toggle.
  logic [31:0] ad_addr;
  initial begin
    bus.ad_ready   = 1'b0;
    bus.ad_line_in = '0;
    forever begin
      @(negedge clk);
      if (bus.ad_toggle && !rst) begin
        ad_addr = bus.ad_line_addr;
        if (bus.ad_we) mem[ad_addr] = bus.ad_line_out;
        repeat (9) @(posedge clk);
        #1;
        bus.ad_line_in = mem.exists(ad_addr) ? mem[ad_addr] : '0;
        bus.ad_ready   = 1'b1;
        @(posedge clk);
        #1;
        bus.ad_ready   = 1'b0;
      end
    end
  end

  // Monitor: compares CPU completions and adapter transfer starts against the queues.
  cpu_exp_t mon_ce;
  ad_exp_t  mon_ae;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ad_re && bus.ad_we) overlap_cnt++;
      if ((bus.cpu_re || bus.cpu_we) && !bus.cpu_stall) begin
        if (cpu_q.size() == 0) fail_now("unexpected_completion");
        else begin
          mon_ce = cpu_q.pop_front();
          if (mon_ce.is_load) check_word("load_rdata", bus.cpu_rdata, mon_ce.rdata);
        end
      end
      if (bus.ad_toggle) begin
        if (ad_q.size() == 0) fail_now("unexpected_transfer");
        else begin
          mon_ae = ad_q.pop_front();
          check_bit("xfer_we", bus.ad_we, mon_ae.is_write);
          check_bit("xfer_re", bus.ad_re, !mon_ae.is_write);
          check_word("xfer_addr", bus.ad_line_addr, mon_ae.addr);
          if (mon_ae.chk_line) check_line("victim_line", bus.ad_line_out, mon_ae.line);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [255:0] wb_line;
  int           c0;

  initial begin
    bus.cpu_re    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_be    = '0;
    mem[32'h100]  = make_line(8'hA0);
    mem[32'h300]  = make_line(8'hC0);
    mem[32'h500]  = make_line(8'hE0);
    wb_line        = make_line(8'hA0);
    wb_line[63:32] = 32'h0000_BEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_ad_re", bus.ad_re, 1'b0);
    check_bit("rst_ad_we", bus.ad_we, 1'b0);
    check_bit("rst_ad_toggle", bus.ad_toggle, 1'b0);
    check_bit("rst_cpu_stall", bus.cpu_stall, 1'b0);
    check_word("rst_ad_line_addr", bus.ad_line_addr, 32'h0);
    check_word("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold load, then hit store and hit load of the merged word.
    push_ad(1'b0, 32'h100, 1'b0, '0);
    do_req(1'b0, 32'h104, 32'h0, 4'h0, 32'h0000_00A1, 12);
    do_req(1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011, 32'h0, 0);
    do_req(1'b0, 32'h104, 32'h0, 4'h0, 32'h0000_BEEF, 0);

    // Dirty conflict miss: evict 0x100, refill 0x300.
    push_ad(1'b1, 32'h100, 1'b1, wb_line);
    push_ad(1'b0, 32'h300, 1'b0, '0);
    do_req(1'b0, 32'h304, 32'h0, 4'h0, 32'h0000_00C1, 22);

    // Clean conflict miss: refill only; memory now holds the written-back word.
    push_ad(1'b0, 32'h100, 1'b0, '0);
    do_req(1'b0, 32'h104, 32'h0, 4'h0, 32'h0000_BEEF, 12);

    // Zero-byte-enable store hits, changes nothing, but still dirties the line.
    do_req(1'b1, 32'h108, 32'hFFFF_FFFF, 4'b0000, 32'h0, 0);
    do_req(1'b0, 32'h108, 32'h0, 4'h0, 32'h0000_00A2, 0);
    push_ad(1'b1, 32'h100, 1'b1, wb_line);
    push_ad(1'b0, 32'h300, 1'b0, '0);
    do_req(1'b0, 32'h30C, 32'h0, 4'h0, 32'h0000_00C3, 22);

    // Reset three cycles into a clean ALLOCATE.
    push_ad(1'b0, 32'h500, 1'b0, '0);
    bus.cpu_re   = 1'b1;
    bus.cpu_addr = 32'h504;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst        = 1'b1;
    bus.cpu_re = 1'b0;
    @(negedge clk);
    check_bit("ad_re_before_rst", bus.ad_re, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_bit("ad_re_after_rst", bus.ad_re, 1'b0);
    check_bit("ad_we_after_rst", bus.ad_we, 1'b0);
    check_bit("stall_after_rst", bus.cpu_stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    check_bit("ready_in_idle_ignored", bus.ad_re | bus.ad_we, 1'b0);

    // Valid bits were cleared, so this misses again.
    push_ad(1'b0, 32'h100, 1'b0, '0);
    do_req(1'b0, 32'h104, 32'h0, 4'h0, 32'h0000_BEEF, 12);

    // Back-to-back hits across all eight words of the line.
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0,
             (i == 1) ? 32'h0000_BEEF : 32'h0000_00A0 + 32'(i), 0);
    end
    check_word("b2b_cycles", 32'(cyc - c0), 32'd8);

    repeat (5) @(posedge clk);
    check_word("cpu_queue_left", 32'(cpu_q.size()), 32'd0);
    check_word("xfer_queue_left", 32'(ad_q.size()), 32'd0);
    check_word("re_we_overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
